// File: rtl/fib_gen_if.sv
// Request/result bundle for fib_gen: start/index/mode/abort in, term/flags out.
// Latency: none (wires only).
// Backpressure: none; the requester watches ready before asserting start.
interface fib_gen_if #(
  parameter int DW = 20,
  parameter int IW = 5
);
  logic          start;
  logic [IW-1:0] i;
  logic          mode;
  logic          abort;
  logic [DW-1:0] f;
  logic          ready;
  logic          done_tick;
  logic          ovf;

  // requester side
  modport master (
    output start, i, mode, abort,
    input  f, ready, done_tick, ovf
  );

  // generator side
  modport slave (
    input  start, i, mode, abort,
    output f, ready, done_tick, ovf
  );
endinterface

// File: rtl/fib_gen.sv
// Iterative Fibonacci/Lucas term generator; one add per cycle. Optional macro FIB_SAT_EN saturates the sum.
// Latency: start at edge E0, done_tick during the cycle after E(i+1), ready back at E(i+2).
// Backpressure: start is accepted only while ready=1; start in OP/DONE is ignored, abort cancels a run.
module fib_gen #(
  parameter int DW = 20,
  parameter int IW = 5
) (
  input  logic   clk,
  input  logic   reset_n,
  fib_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [IW-1:0] n;
  logic          a_ovf;
  logic          b_ovf;
  logic [DW-1:0] f_q;
  logic          ovf_q;
  logic          ready_q;
  logic          done_q;

  // single DW-bit adder; the extra top bit is the carry out
  logic [DW:0]   sum_full;
  logic          carry;
  logic [DW-1:0] b_next;
  logic [DW-1:0] seed0;
  logic [DW-1:0] seed1;

  assign sum_full = {1'b0, a} + {1'b0, b};
  assign carry    = sum_full[DW];

`ifdef FIB_SAT_EN
  // a carried sum clamps to all-ones; later terms inherit the clamp through a
  assign b_next = carry ? {DW{1'b1}} : sum_full[DW-1:0];
`else
  // wrap modulo 2^DW; the flag still records that the true value was lost
  assign b_next = sum_full[DW-1:0];
`endif

  // Lucas starts 2,1; Fibonacci starts 0,1
  assign seed0 = bus.mode ? DW'(2) : '0;
  assign seed1 = DW'(1);

  // FSM plus datapath; all outputs are registered here
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      n       <= '0;
      a_ovf   <= 1'b0;
      b_ovf   <= 1'b0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a       <= seed0;
            b       <= seed1;
            n       <= bus.i;
            a_ovf   <= 1'b0;
            b_ovf   <= 1'b0;
            ready_q <= 1'b0;
            state   <= OP;
          end
        end
        OP: begin
          if (bus.abort) begin
            // f/ovf untouched: the previous result stays visible
            ready_q <= 1'b1;
            state   <= IDLE;
          end else if (n == '0) begin
            // a holds term i; b is the look-ahead and never reaches f
            f_q    <= a;
            ovf_q  <= a_ovf;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            a     <= b;
            b     <= b_next;
            n     <= n - 1'b1;
            a_ovf <= b_ovf;
            b_ovf <= b_ovf | a_ovf | carry;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.f         = f_q;
  assign bus.ovf       = ovf_q;
  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;

endmodule
